// File: rtl/pci_arb_pkg.sv
// rtl/pci_arb_pkg.sv - shared types and constants for the PCI bus arbiter
//
// Purpose : arbiter state encoding and the active-low signalling levels used
//           on REQ/GNT/FRAME/IRDY by the arbiter and by the bus devices.
// Ports   : none (package).
package pci_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT  = 2'd1,
      XFER   = 2'd2,
      SWITCH = 2'd3
   } arb_state_t;

   localparam logic ACT   = 1'b0;
   localparam logic INACT = 1'b1;

endpackage

// File: rtl/pci_bus_arbiter_rr_picker.sv
// rtl/pci_bus_arbiter_rr_picker.sv - combinational round-robin priority search
//
// Purpose : finds the first active request at or after the pointer, wrapping
//           around the request vector.
// Ports   : req    in  N      request per master, active high
//           ptr    in  IDX_W  index searched first
//           winner out IDX_W  index of the chosen master (0 when none)
//           valid  out 1      at least one request is active
module rr_picker #(
   parameter int N     = 4,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [IDX_W-1:0] winner,
   output logic             valid
);

   // Walk the offsets from farthest to nearest so the nearest active
   // request is the last one written and therefore wins.
   always_comb begin
      winner = '0;
      valid  = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[(int'(ptr) + i) % N]) begin
            winner = IDX_W'((int'(ptr) + i) % N);
            valid  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pci_bus_arbiter.sv
// rtl/pci_bus_arbiter.sv - central round-robin PCI bus arbiter
//
// Purpose : samples active-low REQ lines, grants the bus round-robin on
//           active-low GNT lines, inserts a one-clock turnaround between
//           grants, revokes unused grants and preempts a bus owner when
//           another master requests (hidden arbitration).
// Ports   : CLK      in  1          bus clock
//           RST      in  1          asynchronous active-high reset
//           REQ      in  N_MASTERS  request per master, active low
//           FRAME    in  1          bus FRAME, active low
//           IRDY     in  1          bus IRDY, active low
//           GNT      out N_MASTERS  grant per master, active low, at most one low
//           GNT_IDX  out IDX_W      index of the current or last granted master
//           BUS_BUSY out 1          transaction in progress (registered)
module pci_bus_arbiter
   import pci_arb_pkg::*;
#(
   parameter int N_MASTERS   = 4,
   parameter int GNT_TIMEOUT = 16,
   parameter int IDX_W       = $clog2(N_MASTERS)
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [N_MASTERS-1:0] REQ,
   input  logic                 FRAME,
   input  logic                 IRDY,
   output logic [N_MASTERS-1:0] GNT,
   output logic [IDX_W-1:0]     GNT_IDX,
   output logic                 BUS_BUSY
);

   localparam int CNT_W = $clog2(GNT_TIMEOUT + 1);

   arb_state_t           state_q, state_n;
   logic [N_MASTERS-1:0] gnt_q, gnt_n;
   logic [IDX_W-1:0]     owner_q, owner_n;
   logic [IDX_W-1:0]     ptr_q, ptr_n;
   logic [CNT_W-1:0]     cnt_q, cnt_n;
   logic                 busy_q;

   logic [N_MASTERS-1:0] req_act;
   logic [N_MASTERS-1:0] owner_mask;
   logic [IDX_W-1:0]     winner;
   logic                 win_valid;
   logic                 owner_req;
   logic                 others_req;
   logic                 bus_idle;
   logic [IDX_W-1:0]     owner_next_ptr;

   // Only a clean low counts as a request; X/Z on a REQ pin is ignored.
   always_comb begin
      req_act = '0;
      for (int i = 0; i < N_MASTERS; i++) begin
         req_act[i] = (REQ[i] === ACT);
      end
   end

   assign bus_idle   = (FRAME == INACT) && (IRDY == INACT);
   assign owner_mask = N_MASTERS'(1) << owner_q;
   assign owner_req  = |(req_act & owner_mask);
   assign others_req = |(req_act & ~owner_mask);

   // Search start after a transaction: the master following the owner.
   assign owner_next_ptr = (int'(owner_q) == N_MASTERS - 1) ? '0 : owner_q + IDX_W'(1);

   rr_picker #(
      .N     (N_MASTERS),
      .IDX_W (IDX_W)
   ) u_rr_picker (
      .req    (req_act),
      .ptr    (ptr_q),
      .winner (winner),
      .valid  (win_valid)
   );

   always_comb begin
      state_n = state_q;
      gnt_n   = gnt_q;
      owner_n = owner_q;
      ptr_n   = ptr_q;
      cnt_n   = cnt_q;

      case (state_q)
         // IDLE and SWITCH differ only in how they are entered; both hold
         // GNT high this clock, which is what gives the turnaround cycle.
         IDLE, SWITCH: begin
            gnt_n = '1;
            if (FRAME == ACT) begin
               // Stray or parked master driving the bus: track it, grant nobody.
               state_n = XFER;
            end else if (win_valid) begin
               state_n = GRANT;
               gnt_n   = ~(N_MASTERS'(1) << winner);
               owner_n = winner;
               cnt_n   = '0;
            end else begin
               state_n = IDLE;
            end
         end

         GRANT: begin
            if (FRAME == ACT) begin
               state_n = XFER;
               ptr_n   = owner_next_ptr;
            end else if (!owner_req) begin
               state_n = SWITCH;
               gnt_n   = '1;
            end else if (cnt_q == CNT_W'(GNT_TIMEOUT - 1)) begin
               state_n = SWITCH;
               gnt_n   = '1;
            end else begin
               cnt_n = cnt_q + CNT_W'(1);
            end
         end

         XFER: begin
            if (bus_idle) begin
               state_n = SWITCH;
               gnt_n   = '1;
            end else if (!owner_req || others_req) begin
               // Once dropped, GNT stays high for the rest of the transaction.
               gnt_n = '1;
            end
         end

         default: begin
            state_n = IDLE;
            gnt_n   = '1;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         gnt_q   <= '1;
         owner_q <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_n;
         gnt_q   <= gnt_n;
         owner_q <= owner_n;
         ptr_q   <= ptr_n;
         cnt_q   <= cnt_n;
         busy_q  <= !bus_idle;
      end
   end

   assign GNT      = gnt_q;
   assign GNT_IDX  = owner_q;
   assign BUS_BUSY = busy_q;

   // At most one grant line may be low at any time.
   gnt_one_hot_low : assert property (@(posedge CLK) disable iff (RST)
      $countones(~GNT) <= 1);

endmodule
